// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the windowed sum accumulator.
package sum_acc_pkg;

    localparam int SWIDTH_DEF    = 9;
    localparam int CNT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/win_counter.sv
// Window sample counter: latches the window length on load and flags when
// the next increment will reach it.
module win_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_len,
    output logic             term_cnt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;

    // A load counts the sample that opens the window, so it starts at one.
    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        if (load) begin
            count_d = ONE;
            len_d   = load_len;
        end else if (inc) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign term_cnt = ((count_q + ONE) == len_q);

endmodule

// File: rtl/sum_window_acc.sv
// Accumulates sum/zero-count/max over a window of accepted samples and holds
// the result under valid/ready handshake until the consumer takes it.
module sum_window_acc
    import sum_acc_pkg::*;
#(
    parameter int SWIDTH    = SWIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int ACC_WIDTH = SWIDTH + CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SWIDTH-1:0]    in_sum,
    input  logic                 in_zero,
    input  logic [CNT_WIDTH-1:0] win_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0] out_zero_cnt,
    output logic [SWIDTH-1:0]    out_max,
    output logic                 busy
);

    state_e state_q, state_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] zcnt_q, zcnt_d;
    logic [SWIDTH-1:0]    max_q, max_d;
    logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
    logic [CNT_WIDTH-1:0] out_zero_cnt_q, out_zero_cnt_d;
    logic [SWIDTH-1:0]    out_max_q, out_max_d;

    logic                 accept;
    logic                 start;
    logic                 accum_inc;
    logic                 load_out;
    logic                 win_last;
    logic                 len_is_one;
    logic [CNT_WIDTH-1:0] eff_len;

    assign accept     = in_valid & in_ready;
    assign start      = accept & (state_q != ST_ACCUM);
    assign accum_inc  = accept & (state_q == ST_ACCUM);
    assign eff_len    = (win_len == '0) ? CNT_WIDTH'(1) : win_len;
    assign len_is_one = (eff_len == CNT_WIDTH'(1));

    win_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_win_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .inc      (accum_inc),
        .load_len (eff_len),
        .term_cnt (win_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD can only accept while retiring, which restarts a window directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = len_is_one ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && win_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = len_is_one ? ST_HOLD : ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_HOLD);
        busy      = (state_q != ST_IDLE);
        in_ready  = ~out_valid | out_ready;
    end

    always_comb begin
        acc_d  = acc_q;
        zcnt_d = zcnt_q;
        max_d  = max_q;
        if (start) begin
            acc_d  = ACC_WIDTH'(in_sum);
            zcnt_d = CNT_WIDTH'(in_zero);
            max_d  = in_sum;
        end else if (accum_inc) begin
            acc_d  = acc_q + ACC_WIDTH'(in_sum);
            zcnt_d = zcnt_q + CNT_WIDTH'(in_zero);
            max_d  = (in_sum > max_q) ? in_sum : max_q;
        end
    end

    // Every entry into HOLD coincides with the window's final accepted sample.
    always_comb begin
        load_out       = accept & (state_d == ST_HOLD);
        out_acc_d      = out_acc_q;
        out_zero_cnt_d = out_zero_cnt_q;
        out_max_d      = out_max_q;
        if (load_out) begin
            out_acc_d      = acc_d;
            out_zero_cnt_d = zcnt_d;
            out_max_d      = max_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            zcnt_q         <= '0;
            max_q          <= '0;
            out_acc_q      <= '0;
            out_zero_cnt_q <= '0;
            out_max_q      <= '0;
        end else begin
            acc_q          <= acc_d;
            zcnt_q         <= zcnt_d;
            max_q          <= max_d;
            out_acc_q      <= out_acc_d;
            out_zero_cnt_q <= out_zero_cnt_d;
            out_max_q      <= out_max_d;
        end
    end

    assign out_acc      = out_acc_q;
    assign out_zero_cnt = out_zero_cnt_q;
    assign out_max      = out_max_q;

endmodule

// File: tb/tb_sum_window_acc.sv
// Self-checking bench for sum_window_acc: directed scenarios plus a random
// handshake run against a queue-based window model.
module tb_sum_window_acc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_sum;
    logic        in_zero;
    logic [7:0]  win_len;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_acc;
    logic [7:0]  out_zero_cnt;
    logic [8:0]  out_max;
    logic        busy;

    int n_cmp;
    int n_mis;

    bit          exp_valid;
    logic [16:0] exp_acc;
    logic [7:0]  exp_zc;
    logic [8:0]  exp_max;
    int          win_q[$];
    bit          zq[$];
    int          tgt;
    bit          obs_ready;
    bit          exp_ready;

    sum_window_acc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_zero      (in_zero),
        .win_len      (win_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_zero_cnt (out_zero_cnt),
        .out_max      (out_max),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_acc   = '0;
        exp_zc    = '0;
        exp_max   = '0;
        win_q.delete();
        zq.delete();
        tgt = 0;
    endtask

    // Drive one cycle from posedge+1, record in_ready before the edge, and
    // advance the window model by the rules of the handshake.
    task automatic drive_cycle(input bit v, input int s, input bit z, input int wl, input bit ordy);
        bit acc_now;
        int sum;
        int zc;
        int mx;
        in_valid  = v;
        in_sum    = 9'(s);
        in_zero   = z;
        win_len   = 8'(wl);
        out_ready = ordy;
        @(negedge clk);
        obs_ready = in_ready;
        exp_ready = !exp_valid || ordy;
        @(posedge clk);
        acc_now = v && (!exp_valid || ordy);
        if (exp_valid && ordy) exp_valid = 1'b0;
        if (acc_now) begin
            if (win_q.size() == 0) tgt = (wl == 0) ? 1 : wl;
            win_q.push_back(s);
            zq.push_back(z);
            if (win_q.size() == tgt) begin
                sum = 0;
                zc  = 0;
                mx  = 0;
                foreach (win_q[i]) begin
                    sum += win_q[i];
                    if (zq[i]) zc++;
                    if (win_q[i] > mx) mx = win_q[i];
                end
                exp_acc   = 17'(sum);
                exp_zc    = 8'(zc);
                exp_max   = 9'(mx);
                exp_valid = 1'b1;
                win_q.delete();
                zq.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_zero   = 1'b0;
        win_len   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_valid: got %0d expected 0", out_valid); end
        n_cmp++; if (out_acc !== 17'd0) begin n_mis++; $display("[TB] FAIL reset_acc: got %0d expected 0", out_acc); end
        n_cmp++; if (out_zero_cnt !== 8'd0) begin n_mis++; $display("[TB] FAIL reset_zc: got %0d expected 0", out_zero_cnt); end
        n_cmp++; if (out_max !== 9'd0) begin n_mis++; $display("[TB] FAIL reset_max: got %0d expected 0", out_max); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_busy: got %0d expected 0", busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_basic_window();
        drive_cycle(1, 3, 0, 4, 1);
        drive_cycle(1, 0, 1, 4, 1);
        drive_cycle(1, 7, 0, 4, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_early_valid: got %0d expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("[TB] FAIL basic_busy: got %0d expected 1", busy); end
        drive_cycle(1, 5, 0, 4, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL basic_valid: got %0d expected 1", out_valid); end
        n_cmp++; if (out_acc !== 17'd15) begin n_mis++; $display("[TB] FAIL basic_acc: got %0d expected 15", out_acc); end
        n_cmp++; if (out_zero_cnt !== 8'd1) begin n_mis++; $display("[TB] FAIL basic_zc: got %0d expected 1", out_zero_cnt); end
        n_cmp++; if (out_max !== 9'd7) begin n_mis++; $display("[TB] FAIL basic_max: got %0d expected 7", out_max); end
        drive_cycle(0, 0, 0, 4, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_retire: got %0d expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("[TB] FAIL basic_idle_busy: got %0d expected 0", busy); end
    endtask

    task automatic test_len_zero();
        drive_cycle(1, 9, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL len0_valid: got %0d expected 1", out_valid); end
        n_cmp++; if (out_acc !== 17'd9) begin n_mis++; $display("[TB] FAIL len0_acc: got %0d expected 9", out_acc); end
        n_cmp++; if (out_zero_cnt !== 8'd0) begin n_mis++; $display("[TB] FAIL len0_zc: got %0d expected 0", out_zero_cnt); end
        n_cmp++; if (out_max !== 9'd9) begin n_mis++; $display("[TB] FAIL len0_max: got %0d expected 9", out_max); end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1, 10, 0, 2, 0);
        drive_cycle(1, 20, 0, 2, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL hold_valid: got %0d expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 99, 0, 2, 0);
            n_cmp++; if (obs_ready !== 1'b0) begin n_mis++; $display("[TB] FAIL hold_ready[%0d]: got %0d expected 0", i, obs_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL hold_valid[%0d]: got %0d expected 1", i, out_valid); end
            n_cmp++; if (out_acc !== 17'd30) begin n_mis++; $display("[TB] FAIL hold_acc[%0d]: got %0d expected 30", i, out_acc); end
            n_cmp++; if (out_max !== 9'd20) begin n_mis++; $display("[TB] FAIL hold_max[%0d]: got %0d expected 20", i, out_max); end
        end
        drive_cycle(1, 4, 0, 2, 1);
        n_cmp++; if (obs_ready !== 1'b1) begin n_mis++; $display("[TB] FAIL b2b_ready: got %0d expected 1", obs_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL b2b_retire: got %0d expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("[TB] FAIL b2b_busy: got %0d expected 1", busy); end
        drive_cycle(1, 6, 0, 2, 1);
        n_cmp++; if (out_acc !== 17'd10) begin n_mis++; $display("[TB] FAIL b2b_acc: got %0d expected 10", out_acc); end
        n_cmp++; if (out_max !== 9'd6) begin n_mis++; $display("[TB] FAIL b2b_max: got %0d expected 6", out_max); end
        drive_cycle(0, 0, 0, 2, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 255; i++) drive_cycle(1, 511, 0, 255, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL ovf_valid: got %0d expected 1", out_valid); end
        n_cmp++; if (out_acc !== 17'd130305) begin n_mis++; $display("[TB] FAIL ovf_acc: got %0d expected 130305", out_acc); end
        n_cmp++; if (out_max !== 9'd511) begin n_mis++; $display("[TB] FAIL ovf_max: got %0d expected 511", out_max); end
        n_cmp++; if (out_zero_cnt !== 8'd0) begin n_mis++; $display("[TB] FAIL ovf_zc: got %0d expected 0", out_zero_cnt); end
        drive_cycle(0, 0, 0, 255, 1);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 50, 0, 4, 1);
        drive_cycle(1, 60, 1, 4, 1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_acc !== 17'd0) begin n_mis++; $display("[TB] FAIL rmid_acc: got %0d expected 0", out_acc); end
        n_cmp++; if (out_max !== 9'd0) begin n_mis++; $display("[TB] FAIL rmid_max: got %0d expected 0", out_max); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("[TB] FAIL rmid_busy: got %0d expected 0", busy); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("[TB] FAIL rmid_ready: got %0d expected 1", in_ready); end
        for (int i = 1; i <= 4; i++) drive_cycle(1, i, 0, 4, 1);
        n_cmp++; if (out_acc !== 17'd10) begin n_mis++; $display("[TB] FAIL rmid_post_acc: got %0d expected 10", out_acc); end
        n_cmp++; if (out_zero_cnt !== 8'd0) begin n_mis++; $display("[TB] FAIL rmid_post_zc: got %0d expected 0", out_zero_cnt); end
        n_cmp++; if (out_max !== 9'd4) begin n_mis++; $display("[TB] FAIL rmid_post_max: got %0d expected 4", out_max); end
        drive_cycle(0, 0, 0, 4, 1);
    endtask

    task automatic test_len_change();
        drive_cycle(1, 8, 0, 3, 1);
        drive_cycle(0, 0, 0, 1, 1);
        drive_cycle(0, 0, 0, 1, 1);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("[TB] FAIL lenchg_busy: got %0d expected 1", busy); end
        drive_cycle(1, 0, 1, 1, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL lenchg_early: got %0d expected 0", out_valid); end
        drive_cycle(0, 0, 0, 1, 1);
        drive_cycle(1, 5, 0, 1, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL lenchg_valid: got %0d expected 1", out_valid); end
        n_cmp++; if (out_acc !== 17'd13) begin n_mis++; $display("[TB] FAIL lenchg_acc: got %0d expected 13", out_acc); end
        n_cmp++; if (out_zero_cnt !== 8'd1) begin n_mis++; $display("[TB] FAIL lenchg_zc: got %0d expected 1", out_zero_cnt); end
        n_cmp++; if (out_max !== 9'd8) begin n_mis++; $display("[TB] FAIL lenchg_max: got %0d expected 8", out_max); end
        drive_cycle(0, 0, 0, 1, 1);
    endtask

    task automatic test_random();
        int s;
        bit exp_busy;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 511));
            drive_cycle($urandom_range(0, 3) != 0, s, s == 0,
                        int'($urandom_range(0, 4)), $urandom_range(0, 2) != 0);
            exp_busy = exp_valid || (win_q.size() != 0);
            n_cmp++; if (obs_ready !== exp_ready) begin n_mis++; $display("[TB] FAIL rnd_ready[%0d]: got %0d expected %0d", i, obs_ready, exp_ready); end
            n_cmp++; if (out_valid !== exp_valid) begin n_mis++; $display("[TB] FAIL rnd_valid[%0d]: got %0d expected %0d", i, out_valid, exp_valid); end
            n_cmp++; if (busy !== exp_busy) begin n_mis++; $display("[TB] FAIL rnd_busy[%0d]: got %0d expected %0d", i, busy, exp_busy); end
            if (exp_valid) begin
                n_cmp++; if (out_acc !== exp_acc) begin n_mis++; $display("[TB] FAIL rnd_acc[%0d]: got %0d expected %0d", i, out_acc, exp_acc); end
                n_cmp++; if (out_zero_cnt !== exp_zc) begin n_mis++; $display("[TB] FAIL rnd_zc[%0d]: got %0d expected %0d", i, out_zero_cnt, exp_zc); end
                n_cmp++; if (out_max !== exp_max) begin n_mis++; $display("[TB] FAIL rnd_max[%0d]: got %0d expected %0d", i, out_max, exp_max); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_basic_window();
        test_len_zero();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_len_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sum_window_acc.md
SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

Interface
REQ-001 Parameter SWIDTH, default 9: width of incoming sum samples.
REQ-002 Parameter CNT_WIDTH, default 8: width of window length and zero counter.
REQ-003 Parameter ACC_WIDTH, default SWIDTH+CNT_WIDTH: accumulator width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  a registered sum sample is present.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_sum  input  SWIDTH  registered sum sample (unsigned).
REQ-009 in_zero  input  1  flag: in_sum is zero.
REQ-010 win_len  input  CNT_WIDTH  samples per window; 0 treated as 1.
REQ-011 out_valid  output  1  window result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_acc  output  ACC_WIDTH  sum of all samples in window.
REQ-014 out_zero_cnt  output  CNT_WIDTH  count of samples with in_zero=1.
REQ-015 out_max  output  SWIDTH  largest in_sum in window.
REQ-016 busy  output  1  high while state is ACCUM or HOLD.

Function
REQ-017 FSM states IDLE, ACCUM, HOLD.
- Sample accepted = in_valid & in_ready.
- in_ready = ~out_valid | out_ready.
REQ-018 IDLE, accepted sample:
- latch effective window length (win_len, 0 -> 1);
- acc=in_sum, zcnt=in_zero, max=in_sum, count=1;
- go ACCUM, or HOLD directly if length is 1.
REQ-019 ACCUM, accepted sample:
- acc+=in_sum, zcnt+=in_zero, max=max(max,in_sum), count+=1;
- when count reaches latched length, go HOLD.
REQ-020 win_len changes after the first sample of a window have no effect until the next window.
REQ-021 Entering HOLD:
- out_acc/out_zero_cnt/out_max load the final values;
- out_valid asserts the cycle after the last sample is accepted (latency 1).
REQ-022 Outputs are stable while out_valid=1 and out_ready=0.
- No samples accepted in HOLD unless out_ready=1.
REQ-023 HOLD with out_valid & out_ready:
- result retires;
- a sample accepted that same cycle starts a new window as in REQ-018;
- otherwise go IDLE with out_valid=0.
REQ-024 in_valid=0 cycles in ACCUM hold all state; no timeout.
REQ-025 Arithmetic is unsigned.
- ACC_WIDTH cannot overflow for any window length up to 2^CNT_WIDTH-1.
- out_zero_cnt never exceeds the latched length.
REQ-026 out_max ties keep the existing value; equal values give identical results.

Reset
REQ-027 rst_n low asynchronously forces:
- state IDLE;
- out_valid=0, out_acc=0, out_zero_cnt=0, out_max=0, busy=0;
- internal count, accumulators and latched length to 0.
REQ-028 Reset mid-window or in HOLD discards the partial or pending result.
- After release, in_ready=1 in the first cycle.

Structure
REQ-029 Package sum_acc_pkg holds:
- the FSM state enum;
- the default SWIDTH and CNT_WIDTH constants.
REQ-030 Sub-module win_counter (load, increment, terminal-count flag) implements the window sample counter.
- All other logic is inline.

Verification
REQ-031 win_len=4; samples 3,0,7,5 back-to-back; out_ready=1 -> out_valid one cycle after 4th sample, out_acc=15, out_zero_cnt=1, out_max=7.
REQ-032 win_len=0; single sample 9 -> window of 1, out_acc=9, out_zero_cnt=0, out_max=9, out_valid next cycle.
REQ-033 win_len=2; result held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> result retires and new sample starts next window the same cycle.
REQ-034 win_len=255; all samples 511 (SWIDTH=9) -> out_acc=130305, no overflow.
REQ-035 rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; next window of 4 samples reports only post-reset samples.
REQ-036 win_len=3; win_len changed to 1 after first sample; in_valid gaps between samples -> window still closes after 3 samples with correct totals.
